// File: rtl/pe_psum_accum_pkg.sv
// Shared defaults and FSM encoding for the conv PE partial-sum accumulator.
package pe_psum_accum_pkg;

   localparam int unsigned TOUT_DEF   = 4;
   localparam int unsigned W_PSUM_DEF = 32;
   localparam int unsigned W_SIZE_DEF = 9;
   localparam int unsigned W_TILE_DEF = 8;
   localparam int unsigned AW_DEF     = 12;

   typedef enum logic [1:0] {
      PSA_IDLE  = 2'd0,
      PSA_RUN   = 2'd1,
      PSA_DRAIN = 2'd2
   } psa_state_e;

endpackage

// File: rtl/pe_psum_accum_psum_ram.sv
// Simple dual-port psum store: registered read, read returns pre-write contents.
module psum_ram
   import pe_psum_accum_pkg::*;
#(
   parameter int unsigned DW = TOUT_DEF * W_PSUM_DEF,
   parameter int unsigned AW = AW_DEF
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   localparam int unsigned DEPTH = 1 << AW;

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/pe_psum_accum.sv
// Partial-sum accumulator: running sums per pixel across channel tiles,
// emitting finished (optionally ReLU'd) vectors on the last tile.
module pe_psum_accum
   import pe_psum_accum_pkg::*;
#(
   parameter int unsigned TOUT   = TOUT_DEF,
   parameter int unsigned W_PSUM = W_PSUM_DEF,
   parameter int unsigned W_SIZE = W_SIZE_DEF,
   parameter int unsigned W_TILE = W_TILE_DEF,
   parameter int unsigned AW     = AW_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cfg_start,
   input  logic [W_SIZE-1:0]      cfg_width,
   input  logic [W_SIZE-1:0]      cfg_height,
   input  logic [W_TILE-1:0]      cfg_ntile,
   input  logic                   cfg_relu,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   input  logic                   in_vld,
   output logic                   in_rdy,
   input  logic [W_SIZE-1:0]      in_row,
   input  logic [W_SIZE-1:0]      in_col,
   input  logic [TOUT*W_PSUM-1:0] in_acc,
   output logic                   out_vld,
   input  logic                   out_rdy,
   output logic [TOUT*W_PSUM-1:0] out_data,
   output logic [W_SIZE-1:0]      out_row,
   output logic [W_SIZE-1:0]      out_col,
   output logic                   out_last
);

   localparam int unsigned W_VEC = TOUT * W_PSUM;
   localparam int unsigned W_PIX = 2 * W_SIZE;
   localparam int unsigned W_LIN = W_PIX + 1;

   psa_state_e          state_q, state_d;
   logic                busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic [W_PIX-1:0]    pix_cnt_q, pix_cnt_d, npix_q;
   logic [W_TILE-1:0]   tile_cnt_q, tile_cnt_d, ntile_q;
   logic [W_SIZE-1:0]   width_q, height_q;
   logic                relu_q;

   logic                cfg_fire, acc_fire, pix_wrap, tile_first, tile_last, frame_end;
   logic                oob, drain_ok, wr_en, produce;
   logic [AW-1:0]       addr0;
   logic [W_VEC-1:0]    rd_data, base_v, sum_v, res_v;

   logic                s1_vld_q, s1_first_q, s1_last_q, s1_oob_q, s1_end_q, s1_fwd_q;
   logic [AW-1:0]       s1_addr_q;
   logic [W_VEC-1:0]    s1_acc_q, s1_fwd_data_q;
   logic [W_SIZE-1:0]   s1_row_q, s1_col_q;

   logic                skid_vld_q, skid_last_q;
   logic [W_VEC-1:0]    skid_data_q;
   logic [W_SIZE-1:0]   skid_row_q, skid_col_q;

   logic                out_vld_q, out_last_q;
   logic [W_VEC-1:0]    out_data_q;
   logic [W_SIZE-1:0]   out_row_q, out_col_q;

   assign in_rdy     = (state_q == PSA_RUN) && (!out_vld_q || out_rdy);
   assign acc_fire   = in_vld && in_rdy;
   assign cfg_fire   = cfg_start && (state_q == PSA_IDLE);
   assign pix_wrap   = (pix_cnt_q == W_PIX'(npix_q - W_PIX'(1)));
   assign tile_first = (tile_cnt_q == '0);
   assign tile_last  = (tile_cnt_q == W_TILE'(ntile_q - W_TILE'(1)));
   assign frame_end  = acc_fire && pix_wrap && tile_last;
   assign oob        = (in_row >= height_q) || (in_col >= width_q);
   assign addr0      = AW'(W_LIN'(in_row) * W_LIN'(width_q) + W_LIN'(in_col));
   assign wr_en      = s1_vld_q && !s1_oob_q;
   assign produce    = wr_en && s1_last_q;
   // Empty next cycle: nothing in flight and the output register is free or being taken.
   assign drain_ok   = !s1_vld_q && !skid_vld_q && (!out_vld_q || out_rdy);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= PSA_IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         pix_cnt_q  <= '0;
         tile_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         pix_cnt_q  <= pix_cnt_d;
         tile_cnt_q <= tile_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      err_d      = err_q;
      pix_cnt_d  = pix_cnt_q;
      tile_cnt_d = tile_cnt_q;
      case (state_q)
         PSA_IDLE: begin
            if (cfg_start) begin
               state_d    = PSA_RUN;
               busy_d     = 1'b1;
               err_d      = 1'b0;
               pix_cnt_d  = '0;
               tile_cnt_d = '0;
            end
         end
         PSA_RUN: begin
            if (acc_fire) begin
               if (pix_wrap) begin
                  pix_cnt_d  = '0;
                  tile_cnt_d = W_TILE'(tile_cnt_q + W_TILE'(1));
               end else begin
                  pix_cnt_d = W_PIX'(pix_cnt_q + W_PIX'(1));
               end
               if (oob) err_d = 1'b1;
               if (frame_end) state_d = PSA_DRAIN;
            end
         end
         PSA_DRAIN: begin
            if (drain_ok) begin
               state_d = PSA_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: state_d = PSA_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         width_q  <= '0;
         height_q <= '0;
         ntile_q  <= '0;
         relu_q   <= 1'b0;
         npix_q   <= '0;
      end else if (cfg_fire) begin
         width_q  <= cfg_width;
         height_q <= cfg_height;
         ntile_q  <= cfg_ntile;
         relu_q   <= cfg_relu;
         npix_q   <= W_PIX'(cfg_width) * W_PIX'(cfg_height);
      end
   end

   psum_ram #(.DW(W_VEC), .AW(AW)) u_ram (
      .clk     (clk),
      .we_i    (wr_en),
      .waddr_i (s1_addr_q),
      .wdata_i (sum_v),
      .raddr_i (addr0),
      .rdata_o (rd_data)
   );

   // Stage 1; a same-address write in flight is captured for forwarding since the RAM read misses it.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld_q      <= 1'b0;
         s1_first_q    <= 1'b0;
         s1_last_q     <= 1'b0;
         s1_oob_q      <= 1'b0;
         s1_end_q      <= 1'b0;
         s1_fwd_q      <= 1'b0;
         s1_addr_q     <= '0;
         s1_acc_q      <= '0;
         s1_fwd_data_q <= '0;
         s1_row_q      <= '0;
         s1_col_q      <= '0;
      end else begin
         s1_vld_q <= acc_fire;
         if (acc_fire) begin
            s1_first_q    <= tile_first;
            s1_last_q     <= tile_last;
            s1_oob_q      <= oob;
            s1_end_q      <= frame_end;
            s1_fwd_q      <= wr_en && (s1_addr_q == addr0);
            s1_addr_q     <= addr0;
            s1_acc_q      <= in_acc;
            s1_fwd_data_q <= sum_v;
            s1_row_q      <= in_row;
            s1_col_q      <= in_col;
         end
      end
   end

   always_comb begin
      base_v = s1_fwd_q ? s1_fwd_data_q : rd_data;
      if (s1_first_q) base_v = '0;
      sum_v = '0;
      res_v = '0;
      for (int unsigned g = 0; g < TOUT; g++) begin
         sum_v[g*W_PSUM +: W_PSUM] = base_v[g*W_PSUM +: W_PSUM] + s1_acc_q[g*W_PSUM +: W_PSUM];
         res_v[g*W_PSUM +: W_PSUM] = (relu_q && sum_v[g*W_PSUM + W_PSUM - 1]) ? '0
                                                                             : sum_v[g*W_PSUM +: W_PSUM];
      end
   end

   // Output register plus one skid entry for a result arriving while the output stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_vld_q   <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
         out_row_q   <= '0;
         out_col_q   <= '0;
         skid_vld_q  <= 1'b0;
         skid_last_q <= 1'b0;
         skid_data_q <= '0;
         skid_row_q  <= '0;
         skid_col_q  <= '0;
      end else if (!out_vld_q || out_rdy) begin
         if (skid_vld_q) begin
            out_vld_q  <= 1'b1;
            out_data_q <= skid_data_q;
            out_row_q  <= skid_row_q;
            out_col_q  <= skid_col_q;
            out_last_q <= skid_last_q;
            skid_vld_q <= 1'b0;
         end else if (produce) begin
            out_vld_q  <= 1'b1;
            out_data_q <= res_v;
            out_row_q  <= s1_row_q;
            out_col_q  <= s1_col_q;
            out_last_q <= s1_end_q;
         end else begin
            out_vld_q <= 1'b0;
         end
      end else if (produce) begin
         skid_vld_q  <= 1'b1;
         skid_data_q <= res_v;
         skid_row_q  <= s1_row_q;
         skid_col_q  <= s1_col_q;
         skid_last_q <= s1_end_q;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;
   assign out_vld  = out_vld_q;
   assign out_data = out_data_q;
   assign out_row  = out_row_q;
   assign out_col  = out_col_q;
   assign out_last = out_last_q;

endmodule

// File: tb/tb_pe_psum_accum.sv
// Scoreboard bench for pe_psum_accum: a psum model predicts every output vector.
module tb_pe_psum_accum;

   localparam int unsigned VW = 128;

   typedef struct packed {
      logic [VW-1:0] data;
      logic [8:0]    row;
      logic [8:0]    col;
      logic          last;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst, cfg_start, cfg_relu, in_vld, out_rdy;
   logic          busy, done, err, in_rdy, out_vld, out_last;
   logic [8:0]    cfg_width, cfg_height, in_row, in_col, out_row, out_col;
   logic [7:0]    cfg_ntile;
   logic [VW-1:0] in_acc, out_data;
   logic          rdy_man, rdy_rnd, rnd_en;

   int            n_chk = 0;
   int            n_pass = 0;
   int            done_cnt = 0;
   bit            prev_last_hs = 1'b0;
   exp_t          sb[$];
   exp_t          e_mon;
   logic [VW-1:0] tile_acc [8];
   logic [VW-1:0] model_mem [64];
   int            oob_idx, stall_idx, abort_idx;

   always #5 clk = ~clk;
   assign out_rdy = rdy_man & rdy_rnd;

   pe_psum_accum dut (
      .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_width(cfg_width),
      .cfg_height(cfg_height), .cfg_ntile(cfg_ntile), .cfg_relu(cfg_relu),
      .busy(busy), .done(done), .err(err), .in_vld(in_vld), .in_rdy(in_rdy),
      .in_row(in_row), .in_col(in_col), .in_acc(in_acc), .out_vld(out_vld),
      .out_rdy(out_rdy), .out_data(out_data), .out_row(out_row), .out_col(out_col),
      .out_last(out_last)
   );

   task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [VW-1:0] lanes4(input int a, input int b, input int c, input int d);
      return {32'(d), 32'(c), 32'(b), 32'(a)};
   endfunction

   function automatic logic [VW-1:0] add_lanes(input logic [VW-1:0] a, input logic [VW-1:0] b);
      logic [VW-1:0] r;
      for (int g = 0; g < 4; g++) r[g*32 +: 32] = a[g*32 +: 32] + b[g*32 +: 32];
      return r;
   endfunction

   function automatic logic [VW-1:0] relu4(input logic [VW-1:0] a);
      logic [VW-1:0] r;
      for (int g = 0; g < 4; g++) r[g*32 +: 32] = a[g*32 + 31] ? 32'd0 : a[g*32 +: 32];
      return r;
   endfunction

   always @(posedge clk) begin
      #1;
      rdy_rnd = rnd_en ? ($urandom_range(0, 3) != 0) : 1'b1;
   end

   // Output monitor: sampled mid-cycle, pops the scoreboard on each handshake.
   always @(negedge clk) begin
      if (prev_last_hs) begin
         chk("done_after_last", 128'(done), 128'(1));
         chk("busy_fall", 128'(busy), 128'(0));
      end
      prev_last_hs = out_vld && out_rdy && out_last;
      if (done) done_cnt++;
      if (out_vld && out_rdy) begin
         if (sb.size() == 0) begin
            chk("unexpected_out", 128'(sb.size()), 128'(1));
         end else begin
            e_mon = sb.pop_front();
            chk("out_data", out_data, e_mon.data);
            chk("out_row", 128'(out_row), 128'(e_mon.row));
            chk("out_col", 128'(out_col), 128'(e_mon.col));
            chk("out_last", 128'(out_last), 128'(e_mon.last));
         end
      end
   end

   task automatic send(input int r, input int c, input logic [VW-1:0] acc);
      bit ok = 1'b0;
      in_vld = 1'b1;
      in_row = 9'(r);
      in_col = 9'(c);
      in_acc = acc;
      for (int t = 0; t < 200 && !ok; t++) begin
         @(negedge clk);
         ok = in_rdy;
      end
      chk("in_accept", 128'(ok), 128'(1));
      @(posedge clk);
      #1;
      in_vld = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_busy"}, 128'(busy), 128'(0));
      chk({tag, "_done"}, 128'(done), 128'(0));
      chk({tag, "_err"}, 128'(err), 128'(0));
      chk({tag, "_in_rdy"}, 128'(in_rdy), 128'(0));
      chk({tag, "_out_vld"}, 128'(out_vld), 128'(0));
      chk({tag, "_out_data"}, out_data, 128'(0));
      chk({tag, "_out_row"}, 128'(out_row), 128'(0));
      chk({tag, "_out_col"}, 128'(out_col), 128'(0));
      chk({tag, "_out_last"}, 128'(out_last), 128'(0));
   endtask

   task automatic run_frame(input int w, input int h, input int nt, input bit relu,
                            input bit rnd, input bit chain);
      int            k = 0;
      int            total = w * h * nt;
      bit            stop = 1'b0;
      bit            seen = 1'b0;
      int            dc;
      logic [VW-1:0] acc;
      exp_t          e;
      if (!chain) begin
         @(posedge clk);
         #1;
      end
      cfg_width = 9'(w); cfg_height = 9'(h); cfg_ntile = 8'(nt); cfg_relu = relu;
      cfg_start = 1'b1;
      @(posedge clk);
      #1;
      cfg_start = 1'b0;
      chk("busy_after_start", 128'(busy), 128'(1));
      chk("err_clear_on_start", 128'(err), 128'(0));
      for (int t = 0; t < nt && !stop; t++) begin
         for (int r = 0; r < h && !stop; r++) begin
            for (int c = 0; c < w && !stop; c++) begin
               if (k == abort_idx) begin
                  stop = 1'b1;
                  rdy_man = 1'b0;
                  repeat (2) @(posedge clk);
                  #1;
                  chk("abort_pending_out", 128'(out_vld), 128'(1));
                  rst = 1'b1;
                  @(posedge clk);
                  #1;
                  check_all_zero("abort");
                  rst = 1'b0;
                  rdy_man = 1'b1;
                  sb.delete();
                  dc = done_cnt;
                  repeat (10) @(posedge clk);
                  #1;
                  chk("no_done_after_abort", 128'(done_cnt), 128'(dc));
                  chk("idle_after_abort", 128'(busy), 128'(0));
               end else begin
                  acc = rnd ? {$urandom, $urandom, $urandom, $urandom} : tile_acc[t];
                  if (k == oob_idx) begin
                     send(r, w, acc);
                  end else begin
                     send(r, c, acc);
                     model_mem[r*w+c] = (t == 0) ? acc : add_lanes(model_mem[r*w+c], acc);
                     if (t == nt - 1) begin
                        e.data = relu ? relu4(model_mem[r*w+c]) : model_mem[r*w+c];
                        e.row  = 9'(r);
                        e.col  = 9'(c);
                        e.last = (k == total - 1);
                        sb.push_back(e);
                     end
                  end
                  if (k == stall_idx) begin
                     rdy_man = 1'b0;
                     for (int s = 0; s < 5; s++) begin
                        @(negedge clk);
                        chk("stall_in_rdy", 128'(in_rdy), 128'(0));
                        chk("stall_out_vld", 128'(out_vld), 128'(1));
                     end
                     @(posedge clk);
                     #1;
                     rdy_man = 1'b1;
                  end
                  k++;
               end
            end
         end
      end
      if (!stop) begin
         for (int t = 0; t < 400 && !seen; t++) begin
            @(negedge clk);
            seen = done;
         end
         chk("done_seen", 128'(seen), 128'(1));
         chk("sb_drained", 128'(sb.size()), 128'(0));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; cfg_start = 1'b0; cfg_relu = 1'b0; in_vld = 1'b0;
      cfg_width = '0; cfg_height = '0; cfg_ntile = '0;
      in_row = '0; in_col = '0; in_acc = '0;
      rdy_man = 1'b1; rdy_rnd = 1'b1; rnd_en = 1'b0;
      oob_idx = -1; stall_idx = -1; abort_idx = -1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;

      tile_acc[0] = lanes4(1, 2, 3, 4);
      run_frame(2, 2, 1, 1'b0, 1'b0, 1'b0);

      tile_acc[0] = lanes4(5, 5, 5, 5);
      tile_acc[1] = lanes4(-2, -2, -2, -2);
      tile_acc[2] = lanes4(7, 7, 7, 7);
      run_frame(3, 3, 3, 1'b0, 1'b0, 1'b0);
      chk("mem_pix_1_1", dut.u_ram.mem_q[4], lanes4(10, 10, 10, 10));

      for (int t = 0; t < 4; t++) tile_acc[t] = lanes4(1, 1, 1, 1);
      run_frame(1, 1, 4, 1'b0, 1'b0, 1'b1);

      tile_acc[0] = lanes4(-5, 0, 3, -1);
      run_frame(2, 1, 1, 1'b1, 1'b0, 1'b0);

      tile_acc[0] = lanes4(100, -7, 0, 3);
      tile_acc[1] = lanes4(-300, 7, 1, -3);
      stall_idx = 6;
      run_frame(2, 2, 2, 1'b0, 1'b0, 1'b0);
      stall_idx = -1;

      rnd_en = 1'b1;
      run_frame(4, 3, 3, 1'b1, 1'b1, 1'b1);
      rnd_en = 1'b0;

      tile_acc[0] = lanes4(9, 8, 7, 6);
      oob_idx = 1;
      run_frame(2, 2, 1, 1'b0, 1'b0, 1'b0);
      oob_idx = -1;
      chk("err_sticky", 128'(err), 128'(1));

      tile_acc[0] = lanes4(11, 12, 13, 14);
      tile_acc[1] = lanes4(1, -1, 2, -2);
      abort_idx = 12;
      run_frame(3, 3, 2, 1'b0, 1'b0, 1'b0);
      abort_idx = -1;

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
